// File: rtl/varredura_display8.sv
// ----------------------------------------------------------------------------
// varredura_display8
// Scan controller for an 8-digit multiplexed BCD seven-segment display.
// Each digit is lit for DIV cycles (ATIVO). It is then followed by BLANK dark
// cycles (APAGADO) before the index advances. BLANK=0 removes the dark state.
// A new frame (8 nibbles plus a digit mask) is written into a shadow buffer.
// It is copied into the active buffer only at the 7->0 index wrap, so a frame
// is never torn mid-scan.
//
// Optional build macro: SUPRESSAO_ZEROS_EN
//   When defined, leading zeros are blanked. Any digit above the highest
//   nonzero enabled digit stays dark. Digit 0 is always shown.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   carga      load strobe, honoured only while pronto=1
//   dados      8 BCD nibbles, digit k = dados[4k+3:4k]
//   mascara    per-digit enable, captured together with dados
//   pronto     shadow buffer free; a load is accepted this cycle
//   en         one-hot digit enable, all zero while blanked
//   digito     nibble of the currently selected digit
//   indice     current digit index (0..7)
//   fim_quadro one-cycle pulse in the first cycle indice=0 after a wrap
// ----------------------------------------------------------------------------
module varredura_display8 #(
    parameter int DIV   = 4,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        carga,
    input  logic [31:0] dados,
    input  logic [7:0]  mascara,
    output logic        pronto,
    output logic [7:0]  en,
    output logic [3:0]  digito,
    output logic [2:0]  indice,
    output logic        fim_quadro
);

    typedef enum logic {
        ATIVO   = 1'b0,
        APAGADO = 1'b1
    } estado_t;

    // The counter only ever holds 0..max(DIV,BLANK)-1.
    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam bit SEM_APAGADO = (BLANK == 0);

    estado_t       estado_reg, estado_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    indice_reg;
    logic [31:0]   ativo_dados_reg, sombra_dados_reg;
    logic [7:0]    ativo_masc_reg, sombra_masc_reg;
    logic          pendente_reg;
    logic          fim_reg;

    logic          avanca;
    logic          fronteira;
    logic          aceita;
    logic [7:0]    visivel;

    // ------------------------------------------------------------------
    // Next-state logic. avanca marks the edge on which indice moves on.
    // ------------------------------------------------------------------
    always_comb begin
        estado_next = estado_reg;
        cnt_next    = cnt_reg + 1'b1;
        avanca      = 1'b0;
        case (estado_reg)
            ATIVO: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (SEM_APAGADO) begin
                        avanca = 1'b1;
                    end else begin
                        estado_next = APAGADO;
                    end
                end
            end
            APAGADO: begin
                if (cnt_reg == BLANK_LAST) begin
                    cnt_next    = '0;
                    avanca      = 1'b1;
                    estado_next = ATIVO;
                end
            end
            default: begin
                estado_next = ATIVO;
                cnt_next    = '0;
            end
        endcase
    end

    assign fronteira = avanca && (indice_reg == 3'd7);
    // A load is accepted only while the shadow buffer is free. A boundary
    // copy happens only while it is full, so the two never collide. A load
    // accepted on a boundary edge therefore waits a whole frame.
    assign aceita    = carga && !pendente_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg       <= ATIVO;
            cnt_reg          <= '0;
            indice_reg       <= 3'd0;
            ativo_dados_reg  <= 32'd0;
            ativo_masc_reg   <= 8'd0;
            sombra_dados_reg <= 32'd0;
            sombra_masc_reg  <= 8'd0;
            pendente_reg     <= 1'b0;
            fim_reg          <= 1'b0;
        end else begin
            estado_reg <= estado_next;
            cnt_reg    <= cnt_next;
            fim_reg    <= fronteira;
            if (avanca) begin
                indice_reg <= indice_reg + 3'd1;
            end
            if (aceita) begin
                sombra_dados_reg <= dados;
                sombra_masc_reg  <= mascara;
                pendente_reg     <= 1'b1;
            end else if (fronteira && pendente_reg) begin
                ativo_dados_reg <= sombra_dados_reg;
                ativo_masc_reg  <= sombra_masc_reg;
                pendente_reg    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-digit visibility
    // ------------------------------------------------------------------
`ifdef SUPRESSAO_ZEROS_EN
    // nao_zero[k]: digit k is enabled and holds a nonzero nibble. A digit
    // stays visible when it or any digit above it has nao_zero set. This is
    // derived straight from the active buffer, so it tracks every load.
    logic [7:0] nao_zero;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_supr
            assign nao_zero[gi] = ativo_masc_reg[gi] && (|ativo_dados_reg[4*gi +: 4]);
            if (gi == 0) begin : g_dig0
                assign visivel[gi] = ativo_masc_reg[gi];
            end else begin : g_digk
                assign visivel[gi] = ativo_masc_reg[gi] && (|nao_zero[7:gi]);
            end
        end
    endgenerate
`else
    assign visivel = ativo_masc_reg;
`endif

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign en         = (estado_reg == ATIVO) ? ((8'h01 << indice_reg) & visivel) : 8'h00;
    assign digito     = ativo_dados_reg[{indice_reg, 2'b00} +: 4];
    assign indice     = indice_reg;
    assign pronto     = !pendente_reg;
    assign fim_quadro = fim_reg;

endmodule

// File: tb/tb_varredura_display8.sv
// ----------------------------------------------------------------------------
// Bench for varredura_display8 with DIV=4 and BLANK=2. One digit slot is
// 6 cycles long, and one frame is 48 cycles. cyc counts rising edges since
// reset was released. After edge n the digit index is (n/6)%8, and the digit
// is lit while n%6 < 4.
// ----------------------------------------------------------------------------
module tb_varredura_display8;

    logic        clk;
    logic        rst_n;
    logic        carga;
    logic [31:0] dados;
    logic [7:0]  mascara;
    logic        pronto;
    logic [7:0]  en;
    logic [3:0]  digito;
    logic [2:0]  indice;
    logic        fim_quadro;

    int checks;
    int errors;
    int cyc;

    varredura_display8 #(.DIV(4), .BLANK(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .carga      (carga),
        .dados      (dados),
        .mascara    (mascara),
        .pronto     (pronto),
        .en         (en),
        .digito     (digito),
        .indice     (indice),
        .fim_quadro (fim_quadro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [2:0] idx;
        logic       fim;
        logic [7:0] en;
        logic       pr;
    } idle_t;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] en;
        logic [3:0] dig;
    } walk_t;

    idle_t tab_idle[10];
    walk_t tab_walk[8];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nome, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] m);
        carga   = 1'b1;
        dados   = d;
        mascara = m;
        tick();
        carga = 1'b0;
        $display("load dados=%h mascara=%h edge=%0d pronto_after=%0b", d, m, cyc, pronto);
    endtask

    // Checks a full frame that starts at edge base. m is the set of digits
    // expected to light up.
    task automatic check_frame(input int base, input logic [31:0] d, input logic [7:0] m);
        int idx;
        logic [7:0] exp_en;
        logic [31:0] dd;
        for (int k = 0; k < 48; k++) begin
            step_to(base + k);
            idx    = k / 6;
            exp_en = ((k % 6) < 4) ? ((8'h01 << idx) & m) : 8'h00;
            dd     = d >> (4 * idx);
            chk("frame_en", {24'd0, en}, {24'd0, exp_en});
            chk("frame_digito", {28'd0, digito}, {28'd0, dd[3:0]});
            chk("frame_indice", {29'd0, indice}, 32'(idx));
            chk("frame_fim", {31'd0, fim_quadro}, (k == 0) ? 32'd1 : 32'd0);
        end
        $display("frame at edge %0d dados=%h visible=%h checked", base, d, m);
    endtask

    initial begin
        logic [7:0] m_sup1;
        logic [7:0] m_sup2;
        checks = 0;
        errors = 0;
        cyc    = 0;

        tab_idle[0] = '{0,  3'd0, 1'b0, 8'h00, 1'b1};
        tab_idle[1] = '{5,  3'd0, 1'b0, 8'h00, 1'b1};
        tab_idle[2] = '{6,  3'd1, 1'b0, 8'h00, 1'b1};
        tab_idle[3] = '{11, 3'd1, 1'b0, 8'h00, 1'b1};
        tab_idle[4] = '{12, 3'd2, 1'b0, 8'h00, 1'b1};
        tab_idle[5] = '{47, 3'd7, 1'b0, 8'h00, 1'b1};
        tab_idle[6] = '{48, 3'd0, 1'b1, 8'h00, 1'b1};
        tab_idle[7] = '{49, 3'd0, 1'b0, 8'h00, 1'b1};
        tab_idle[8] = '{95, 3'd7, 1'b0, 8'h00, 1'b1};
        tab_idle[9] = '{96, 3'd0, 1'b1, 8'h00, 1'b1};

        tab_walk[0] = '{3'd0, 8'h01, 4'h0};
        tab_walk[1] = '{3'd1, 8'h02, 4'h1};
        tab_walk[2] = '{3'd2, 8'h04, 4'h2};
        tab_walk[3] = '{3'd3, 8'h08, 4'h3};
        tab_walk[4] = '{3'd4, 8'h10, 4'h4};
        tab_walk[5] = '{3'd5, 8'h20, 4'h5};
        tab_walk[6] = '{3'd6, 8'h40, 4'h6};
        tab_walk[7] = '{3'd7, 8'h80, 4'h7};

`ifdef SUPRESSAO_ZEROS_EN
        m_sup1 = 8'h07;
        m_sup2 = 8'h01;
`else
        m_sup1 = 8'hFF;
        m_sup2 = 8'hFF;
`endif

        rst_n   = 1'b0;
        carga   = 1'b0;
        dados   = 32'd0;
        mascara = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pronto", {31'd0, pronto}, 32'd1);
        chk("rst_en", {24'd0, en}, 32'd0);
        chk("rst_digito", {28'd0, digito}, 32'd0);
        chk("rst_indice", {29'd0, indice}, 32'd0);
        chk("rst_fim", {31'd0, fim_quadro}, 32'd0);
        rst_n = 1'b1;
        cyc   = 0;

        // Idle scan with an empty mask
        for (int i = 0; i < 10; i++) begin
            step_to(tab_idle[i].n);
            chk("idle_indice", {29'd0, indice}, {29'd0, tab_idle[i].idx});
            chk("idle_fim", {31'd0, fim_quadro}, {31'd0, tab_idle[i].fim});
            chk("idle_en", {24'd0, en}, {24'd0, tab_idle[i].en});
            chk("idle_pronto", {31'd0, pronto}, {31'd0, tab_idle[i].pr});
        end

        // Load A, then attempt load B while A is still pending
        step_to(100);
        load(32'h76543210, 8'hFF);
        chk("loadA_pronto", {31'd0, pronto}, 32'd0);
        step_to(110);
        load(32'hAAAAAAAA, 8'h0F);
        chk("loadB_pronto", {31'd0, pronto}, 32'd0);
        step_to(143);
        chk("pre_bound_en", {24'd0, en}, 32'd0);
        step_to(144);
        chk("bound_pronto", {31'd0, pronto}, 32'd1);
        chk("bound_fim", {31'd0, fim_quadro}, 32'd1);

        // Walk frame A
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 6; c++) begin
                step_to(144 + d * 6 + c);
                chk("walk_indice", {29'd0, indice}, {29'd0, tab_walk[d].idx});
                chk("walk_en", {24'd0, en}, (c < 4) ? {24'd0, tab_walk[d].en} : 32'd0);
                chk("walk_digito", {28'd0, digito}, {28'd0, tab_walk[d].dig});
            end
        end

        // Load issued on the boundary edge itself
        step_to(191);
        chk("pre_edge_pronto", {31'd0, pronto}, 32'd1);
        load(32'h11111111, 8'hFF);
        chk("edge_fim", {31'd0, fim_quadro}, 32'd1);
        chk("edge_pronto", {31'd0, pronto}, 32'd0);
        chk("edge_old_dig0", {28'd0, digito}, 32'd0);
        step_to(204);
        chk("edge_old_dig2", {28'd0, digito}, 32'd2);
        chk("edge_old_en2", {24'd0, en}, 32'h04);
        step_to(240);
        chk("next_fim", {31'd0, fim_quadro}, 32'd1);
        chk("next_pronto", {31'd0, pronto}, 32'd1);
        chk("next_dig0", {28'd0, digito}, 32'd1);
        chk("next_en0", {24'd0, en}, 32'h01);
        step_to(252);
        chk("next_dig2", {28'd0, digito}, 32'd1);

        // Reset mid-scan with a frame pending
        step_to(245);
        load(32'h99999999, 8'h0F);
        chk("mid_pronto", {31'd0, pronto}, 32'd0);
        step_to(274);
        chk("mid_indice", {29'd0, indice}, 32'd5);
        chk("mid_blank_en", {24'd0, en}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {24'd0, en}, 32'd0);
        chk("mid_rst_indice", {29'd0, indice}, 32'd0);
        chk("mid_rst_pronto", {31'd0, pronto}, 32'd1);
        chk("mid_rst_digito", {28'd0, digito}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        step_to(30);
        chk("post_rst_en5", {24'd0, en}, 32'd0);
        step_to(54);
        chk("post_rst_en1", {24'd0, en}, 32'd0);
        chk("post_rst_dig1", {28'd0, digito}, 32'd0);

        // Masked digits: slot dark, nibble still on digito
        step_to(60);
        load(32'h00000305, 8'h05);
        check_frame(96, 32'h00000305, 8'h05);

        // Full mask with leading zeros (suppressed only when the macro is set)
        step_to(150);
        load(32'h00000305, 8'hFF);
        check_frame(192, 32'h00000305, m_sup1);
        step_to(290);
        load(32'h00000000, 8'hFF);
        check_frame(336, 32'h00000000, m_sup2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
